// File: rtl/arith_pkg.sv
// Shared helpers for the segmented adder datapath: segment count and
// parameter sanity check used at elaboration time.
package arith_pkg;

    function automatic int nseg(input int width, input int seg_w);
        return width / seg_w;
    endfunction

    function automatic bit seg_cfg_ok(input int width, input int seg_w);
        return (seg_w > 0) && (width >= seg_w) && ((width % seg_w) == 0);
    endfunction

endpackage

// File: rtl/adder_segment.sv
// One SEG_W-bit slice of the segmented adder; purely combinational.
// c_msb_in is the carry into the slice MSB, needed for signed overflow.
module adder_segment #(
    parameter int SEG_W = 4
) (
    input  logic [SEG_W-1:0] a_seg,
    input  logic [SEG_W-1:0] b_seg,
    input  logic             c_in,
    output logic [SEG_W-1:0] s_seg,
    output logic             c_out,
    output logic             c_msb_in
);

    logic [SEG_W:0] total;

    always_comb begin
        total    = {1'b0, a_seg} + {1'b0, b_seg} + {{SEG_W{1'b0}}, c_in};
        s_seg    = total[SEG_W-1:0];
        c_out    = total[SEG_W];
        // sum bit = a ^ b ^ carry-in at that bit, so the carry falls out directly
        c_msb_in = total[SEG_W-1] ^ a_seg[SEG_W-1] ^ b_seg[SEG_W-1];
    end

endmodule

// File: rtl/pipelined_adder.sv
// WIDTH-bit add/subtract resolved SEG_W bits per cycle, with a global
// stall driven by the output handshake.
module pipelined_adder
    import arith_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int SEG_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int NSEG = nseg(WIDTH, SEG_W);

    if (!seg_cfg_ok(WIDTH, SEG_W)) begin : g_cfg_err
        $error("pipelined_adder: WIDTH must be a non-zero multiple of SEG_W");
    end

    // Rank k holds the operand bits not yet consumed (shifted so the next
    // segment sits at the bottom), the carry into segment k, and the sum
    // segments already resolved (shifted in from the top).
    logic [WIDTH-1:0] a_q [NSEG];
    logic [WIDTH-1:0] a_d [NSEG];
    logic [WIDTH-1:0] b_q [NSEG];
    logic [WIDTH-1:0] b_d [NSEG];
    logic [WIDTH-1:0] s_q [NSEG];
    logic [WIDTH-1:0] s_d [NSEG];
    logic [NSEG-1:0]  c_q, c_d;
    logic [NSEG:0]    v_q, v_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             ovf_q, ovf_d;

    logic [SEG_W-1:0] seg_s [NSEG];
    logic             seg_c [NSEG];
    logic             seg_m [NSEG];
    logic             advance;

    function automatic logic [WIDTH-1:0] merge_seg(input logic [WIDTH-1:0] acc,
                                                   input logic [SEG_W-1:0] seg);
        return (acc >> SEG_W) | (WIDTH'(seg) << (WIDTH - SEG_W));
    endfunction

    for (genvar k = 0; k < NSEG; k++) begin : g_seg
        adder_segment #(.SEG_W(SEG_W)) u_seg (
            .a_seg    (a_q[k][SEG_W-1:0]),
            .b_seg    (b_q[k][SEG_W-1:0]),
            .c_in     (c_q[k]),
            .s_seg    (seg_s[k]),
            .c_out    (seg_c[k]),
            .c_msb_in (seg_m[k])
        );
    end

    assign advance   = !v_q[NSEG] || out_ready;
    assign in_ready  = advance;
    assign out_valid = v_q[NSEG];
    assign sum       = sum_q;
    assign cout      = cout_q;
    assign ovf       = ovf_q;

    always_comb begin
        a_d = a_q;
        b_d = b_q;
        s_d = s_q;
        c_d = c_q;
        v_d = {v_q[NSEG-1:0], in_valid};

        a_d[0] = a;
        b_d[0] = b ^ {WIDTH{sub}};
        c_d[0] = sub | cin;
        s_d[0] = '0;
        for (int k = 1; k < NSEG; k++) begin
            a_d[k] = a_q[k-1] >> SEG_W;
            b_d[k] = b_q[k-1] >> SEG_W;
            c_d[k] = seg_c[k-1];
            s_d[k] = merge_seg(s_q[k-1], seg_s[k-1]);
        end

        sum_d  = merge_seg(s_q[NSEG-1], seg_s[NSEG-1]);
        cout_d = seg_c[NSEG-1];
        ovf_d  = seg_m[NSEG-1] ^ seg_c[NSEG-1];
    end

    // Output rank and valid bits: cleared on reset, frozen on stall.
    always_ff @(posedge clk) begin
        if (rst) begin
            v_q    <= '0;
            sum_q  <= '0;
            cout_q <= 1'b0;
            ovf_q  <= 1'b0;
        end else if (advance) begin
            v_q    <= v_d;
            sum_q  <= sum_d;
            cout_q <= cout_d;
            ovf_q  <= ovf_d;
        end
    end

    // Skew, deskew and carry ranks: no reset needed, validity lives in v_q.
    always_ff @(posedge clk) begin
        if (advance) begin
            a_q <= a_d;
            b_q <= b_d;
            s_q <= s_d;
            c_q <= c_d;
        end
    end

endmodule
